// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer helper for sync_fifo.
// Used by the FIFO top and its storage sub-module.
package sync_fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 32;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int FIFO_PTR_DEF   = 4;

    // Explicit wrap at depth-1 so non-power-of-two depths work.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int depth);
        return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Dual-port register array for sync_fifo.
// Synchronous write; registered read that updates only when rd_en is high.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH  = FIFO_WIDTH_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    parameter int ADDR_W = FIFO_PTR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_p1;

    // Storage is not reset; only the output register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // ---- read stage: output register holds when no read ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_p1 <= '0;
        end else if (rd_en) begin
            rd_data_p1 <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_p1;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, full/empty flags and counts.
// Optional simulation checks are compiled in when SYNCH_FIFO_CHECK_EN is defined.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int FIFO_PTR   = FIFO_PTR_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_wren,
    input  logic                  fifo_rden,
    input  logic [FIFO_WIDTH-1:0] fifo_wrdata,
    output logic [FIFO_WIDTH-1:0] fifo_rddata,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [FIFO_PTR:0]     fifo_room_avail,
    output logic [FIFO_PTR:0]     fifo_data_avail
);

    localparam int CNT_W = FIFO_PTR + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [FIFO_PTR-1:0] wr_ptr;
    logic [FIFO_PTR-1:0] rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                wr_acc;
    logic                rd_acc;

    // Acceptance looks only at registered flags, so a full FIFO never takes a write
    // even when a read frees a slot in the same cycle (and likewise for empty).
    assign wr_acc = fifo_wren && !fifo_full;
    assign rd_acc = fifo_rden && !fifo_empty;

    assign fifo_full       = (count == DEPTH_C);
    assign fifo_empty      = (count == '0);
    assign fifo_data_avail = count;
    assign fifo_room_avail = DEPTH_C - count;

    // ---- pointer / occupancy stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= FIFO_PTR'(ptr_inc(32'(wr_ptr), FIFO_DEPTH));
            end
            if (rd_acc) begin
                rd_ptr <= FIFO_PTR'(ptr_inc(32'(rd_ptr), FIFO_DEPTH));
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    sync_fifo_mem #(
        .WIDTH  (FIFO_WIDTH),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (FIFO_PTR)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (fifo_wrdata),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (fifo_rddata)
    );

`ifdef SYNCH_FIFO_CHECK_EN
    always @(posedge clk) begin
        if (rst_n) begin
            if (fifo_wren && fifo_full) begin
                $error("sync_fifo: write attempted while full");
            end
            if (fifo_rden && fifo_empty) begin
                $error("sync_fifo: read attempted while empty");
            end
            assert (count <= DEPTH_C)
                else $error("sync_fifo: count %0d exceeds depth", count);
            assert (!(fifo_full && fifo_empty))
                else $error("sync_fifo: full and empty together");
        end
    end
`else
    // Checks compiled out; behaviour is unchanged.
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue model predicts each cycle's outputs,
// a monitor compares them after every rising edge.
module tb_sync_fifo;

    localparam int W = 32;
    localparam int D = 16;
    localparam int P = 4;

    typedef struct {
        logic [W-1:0] rd;
        int           cnt;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         fifo_wren;
    logic         fifo_rden;
    logic [W-1:0] fifo_wrdata;
    logic [W-1:0] fifo_rddata;
    logic         fifo_full;
    logic         fifo_empty;
    logic [P:0]   fifo_room_avail;
    logic [P:0]   fifo_data_avail;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] model_q[$];
    logic [W-1:0] model_rd;
    exp_t         exp_q[$];

    sync_fifo #(
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (D),
        .FIFO_PTR   (P)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fifo_wren       (fifo_wren),
        .fifo_rden       (fifo_rden),
        .fifo_wrdata     (fifo_wrdata),
        .fifo_rddata     (fifo_rddata),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .fifo_room_avail (fifo_room_avail),
        .fifo_data_avail (fifo_data_avail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle: update the queue model from the spec rules and queue the
    // outputs expected after the coming rising edge.
    task automatic cycle(input logic wr, input logic rd, input logic [W-1:0] data);
        exp_t e;
        bit   wacc;
        bit   racc;
        fifo_wren   = wr;
        fifo_rden   = rd;
        fifo_wrdata = data;
        wacc = wr && (model_q.size() < D);
        racc = rd && (model_q.size() > 0);
        if (racc) model_rd = model_q.pop_front();
        if (wacc) model_q.push_back(data);
        e.rd  = model_rd;
        e.cnt = model_q.size();
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic reset_cycles(input int n);
        exp_t e;
        fifo_wren = 1'b0;
        fifo_rden = 1'b0;
        rst_n     = 1'b0;
        model_q.delete();
        model_rd = '0;
        for (int i = 0; i < n; i++) begin
            e.rd  = '0;
            e.cnt = 0;
            exp_q.push_back(e);
            @(negedge clk);
        end
        rst_n = 1'b1;
    endtask

    // Monitor: outputs are sampled 1 ns after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rddata",     fifo_rddata,           e.rd);
                check("data_avail", W'(fifo_data_avail),   W'(e.cnt));
                check("room_avail", W'(fifo_room_avail),   W'(D - e.cnt));
                check("full",       W'(fifo_full),         W'(e.cnt == D));
                check("empty",      W'(fifo_empty),        W'(e.cnt == 0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish by 200000");
        $fatal(1, "timeout");
    end

    initial begin
        int wp;
        int rp;
        fifo_wren   = 1'b0;
        fifo_rden   = 1'b0;
        fifo_wrdata = '0;
        model_rd    = '0;
        rst_n       = 1'b0;

        // Reset held 50 ns
        reset_cycles(5);
        check("rst_empty", W'(fifo_empty), 1);
        check("rst_full",  W'(fifo_full),  0);
        check("rst_room",  W'(fifo_room_avail), 16);
        check("rst_rddata", fifo_rddata, 0);

        // Fill with 1..16, then one write while full
        for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, W'(i));
        check("fill_full", W'(fifo_full), 1);
        check("fill_cnt",  W'(fifo_data_avail), 16);
        check("fill_room", W'(fifo_room_avail), 0);
        cycle(1'b1, 1'b0, 32'hDEAD_BEEF);
        check("overfill_cnt", W'(fifo_data_avail), 16);

        // Half drain (1..8), refill with 17..24
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 1'b1, '0);
            check("half_drain_word", fifo_rddata, W'(i));
        end
        check("half_cnt", W'(fifo_data_avail), 8);
        for (int i = 17; i <= 24; i++) cycle(1'b1, 1'b0, W'(i));
        check("refill_cnt", W'(fifo_data_avail), 16);

        // Full drain (9..24), then a read while empty
        for (int i = 9; i <= 24; i++) begin
            cycle(1'b0, 1'b1, '0);
            check("drain_word", fifo_rddata, W'(i));
        end
        check("drain_empty", W'(fifo_empty), 1);
        cycle(1'b0, 1'b1, '0);
        check("underflow_rddata", fifo_rddata, 24);
        check("underflow_cnt", W'(fifo_data_avail), 0);

        // Simultaneous read/write at count 5, when full, when empty
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, W'(100 + i));
        cycle(1'b1, 1'b1, 32'd200);
        check("rw_mid_cnt", W'(fifo_data_avail), 5);
        check("rw_mid_rd",  fifo_rddata, 100);
        for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0, W'(300 + i));
        check("pre_full", W'(fifo_full), 1);
        cycle(1'b1, 1'b1, 32'd999);
        check("rw_full_cnt", W'(fifo_data_avail), 15);
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, '0);
        check("pre_empty", W'(fifo_empty), 1);
        cycle(1'b1, 1'b1, 32'd777);
        check("rw_empty_cnt", W'(fifo_data_avail), 1);
        cycle(1'b0, 1'b1, '0);
        check("rw_empty_word", fifo_rddata, 777);

        // Random traffic with shifting write/read bias and a mid-run reset
        for (int c = 0; c < 1000; c++) begin
            case ((c / 100) % 3)
                0:       begin wp = 80; rp = 30; end
                1:       begin wp = 30; rp = 80; end
                default: begin wp = 60; rp = 60; end
            endcase
            if (c == 550) begin
                reset_cycles(2);
                check("midrst_empty", W'(fifo_empty), 1);
                check("midrst_cnt",   W'(fifo_data_avail), 0);
            end
            cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, $urandom);
        end

        cycle(1'b0, 1'b0, '0);
        check("scoreboard_drained", W'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock synchronous FIFO buffering FIFO_WIDTH-bit words between a producer and a consumer in the same clock domain. It provides registered read data, full/empty flags, and occupancy/free-space counts so either side can throttle. Protection is internal: a write when full or a read when empty is dropped and leaves state unchanged.

## Interface
Parameters:
- FIFO_WIDTH, 32, data word width in bits.
- FIFO_DEPTH, 16, number of storage entries; must be ≥2 and ≤2**FIFO_PTR.
- FIFO_PTR, 4, pointer width in bits; counts are FIFO_PTR+1 bits.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- fifo_wren  in  1  write request.
- fifo_rden  in  1  read request.
- fifo_wrdata  in  FIFO_WIDTH  write data, sampled on an accepted write.
- fifo_rddata  out  FIFO_WIDTH  registered read data.
- fifo_full  out  1  occupancy == FIFO_DEPTH.
- fifo_empty  out  1  occupancy == 0.
- fifo_room_avail  out  FIFO_PTR+1  FIFO_DEPTH − occupancy.
- fifo_data_avail  out  FIFO_PTR+1  occupancy.

## Operation
- State: wr_ptr and rd_ptr (FIFO_PTR bits each), count (FIFO_PTR+1 bits), and storage array FIFO_DEPTH×FIFO_WIDTH.
- A write is accepted when fifo_wren && !fifo_full. The block stores fifo_wrdata at wr_ptr, then increments wr_ptr.
- A read is accepted when fifo_rden && !fifo_empty. The block loads mem[rd_ptr] into fifo_rddata, then increments rd_ptr.
- Pointer wrap: the value FIFO_DEPTH−1 advances to 0. The wrap is explicit, so a non-power-of-two depth works.
- Count update: +1 on a write-only cycle, −1 on a read-only cycle, unchanged when both or neither are accepted.
- When full, a write is rejected even if a read is accepted in the same cycle; the read proceeds and count drops to FIFO_DEPTH−1.
- When empty, a read is rejected even if a write is accepted in the same cycle; the write proceeds and count becomes 1. There is no fall-through.
- A rejected request has no effect. fifo_rddata holds its last value whenever no read is accepted.
- Flags and counts are combinational decodes of the count register only, never of the current inputs.

## Timing
- Reset (asynchronous assert, synchronous release): wr_ptr=0, rd_ptr=0, count=0, fifo_rddata=0, fifo_empty=1, fifo_full=0, fifo_data_avail=0, fifo_room_avail=FIFO_DEPTH. Memory contents are not reset.
- Reset asserted mid-operation discards all contents immediately.
- Write latency: data written at edge N is readable by a read request sampled at edge N+1. fifo_empty deasserts after edge N.
- Read latency: for a read accepted at edge N, fifo_rddata is valid after edge N (1 cycle from request).
- fifo_full asserts in the cycle after the edge that stores the FIFO_DEPTH-th word.
- Data order is strictly first-in, first-out.

## Configuration
- SYNCH_FIFO_CHECK_EN: when defined, simulation-only checks issue $error on a write attempt while full and a read attempt while empty. The same checks fire an assertion if count > FIFO_DEPTH or if fifo_full && fifo_empty. Checks are disabled while rst_n=0.
- When undefined, none of these checks are compiled. Functional behaviour is identical either way.

## Structure
- Package sync_fifo_pkg holds the default constants FIFO_WIDTH_DEF=32, FIFO_DEPTH_DEF=16, FIFO_PTR_DEF=4, plus a ptr-increment-with-wrap function.
- Sub-module sync_fifo_mem is a simple dual-port register array: synchronous write, and a synchronous registered read with read enable. It is instantiated once. Pointer, count and flag logic live in sync_fifo.

## Test plan
- Reset: hold rst_n=0 for 50 ns -> fifo_empty=1, fifo_full=0, data_avail=0, room_avail=16, rddata=0.
- Fill: 16 consecutive writes of known values -> fifo_full=1, data_avail=16, room_avail=0. A 17th write while full is dropped and count stays 16.
- Half drain and refill: 8 reads return words 1–8 in order and count becomes 8. Then 8 writes bring count back to 16.
- Full drain: 16 reads return the remaining 16 words in FIFO order -> fifo_empty=1. An extra read leaves rddata unchanged and count at 0.
- Simultaneous read and write: at count=5, count stays 5 and pointers advance. When full, the read is accepted, the write is dropped and count becomes 15. When empty, the write is accepted, the read is dropped and count becomes 1.
- Random: 1000 cycles of random wren/rden/wrdata against a scoreboard queue model -> data, flags and counts match every cycle. Include rst_n asserted mid-run, after which the FIFO reads empty.
